// File: rtl/pcihellocore_seg7_pkg.sv
// Shared constants and the active-high hex decode table for the seven-segment controller.
package pcihellocore_seg7_pkg;

  // Avalon word addresses
  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_CTRL   = 3'd1;
  localparam logic [2:0] ADDR_BLINK  = 3'd2;
  localparam logic [2:0] ADDR_RAW_LO = 3'd3;
  localparam logic [2:0] ADDR_RAW_HI = 3'd4;
  localparam logic [2:0] ADDR_STATUS = 3'd5;
  localparam logic [2:0] ADDR_BRIGHT = 3'd6;

  // CTRL field offsets (bit k of each field = digit k)
  localparam int unsigned CTRL_DECODE_OFS = 0;
  localparam int unsigned CTRL_BLANK_OFS  = 8;
  localparam int unsigned CTRL_BLINK_OFS  = 16;

  // Segment pattern for a dark digit, per output polarity
  localparam logic [6:0] SEG_OFF_ACTIVE_LOW  = 7'h7F;
  localparam logic [6:0] SEG_OFF_ACTIVE_HIGH = 7'h00;

  // Hex nibble -> segments {g,f,e,d,c,b,a}, 1 = lit
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    unique case (nib)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/pcihellocore_seg7_hexdec.sv
// Combinational hex nibble to active-high seven-segment decoder, one per digit.
module pcihellocore_seg7_hexdec
  import pcihellocore_seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Pure table lookup
  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/pcihellocore_seg7_ctrl.sv
// Avalon-MM seven-segment controller: register file, blink timer and registered digit mux.
// Optional build macro SEG7_BRIGHTNESS_EN adds the BRIGHT register and pwm dimming.
module pcihellocore_seg7_ctrl
  import pcihellocore_seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned BLINK_W    = 24,
  parameter logic [6:0]  RESET_SEG  = 7'h40
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [2:0]              address,
  input  logic                    chipselect,
  input  logic                    write_n,
  input  logic [31:0]             writedata,
  output logic [31:0]             readdata,
  output logic [8*NUM_DIGITS-1:0] out_port
);

  localparam logic [6:0] SegOff = ACTIVE_LOW ? SEG_OFF_ACTIVE_LOW : SEG_OFF_ACTIVE_HIGH;

  logic                    wr;
  logic [4*NUM_DIGITS-1:0] value_q;
  logic [NUM_DIGITS-1:0]   decode_q, blank_q, blink_en_q;
  logic [BLINK_W-1:0]      blink_q, cnt_q;
  logic                    phase_q;
  logic [7*NUM_DIGITS-1:0] raw_q;
  logic [8*NUM_DIGITS-1:0] out_d;
  logic                    dim_off;
  logic                    unused_wd;

  assign wr        = chipselect & ~write_n;
  assign unused_wd = ^writedata;

  // Register file writes; raw bytes are kept at pin polarity and driven as-is
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q    <= '0;
      decode_q   <= '0;
      blank_q    <= '0;
      blink_en_q <= '0;
      blink_q    <= '0;
      raw_q      <= {NUM_DIGITS{RESET_SEG}};
    end else if (wr) begin
      case (address)
        ADDR_VALUE: value_q <= writedata[4*NUM_DIGITS-1:0];
        ADDR_CTRL: begin
          decode_q   <= writedata[CTRL_DECODE_OFS +: NUM_DIGITS];
          blank_q    <= writedata[CTRL_BLANK_OFS +: NUM_DIGITS];
          blink_en_q <= writedata[CTRL_BLINK_OFS +: NUM_DIGITS];
        end
        ADDR_BLINK: blink_q <= writedata[BLINK_W-1:0];
        ADDR_RAW_LO: begin
          for (int k = 0; k < NUM_DIGITS; k++) begin
            if (k < 4) raw_q[7*k +: 7] <= writedata[8*k +: 7];
          end
        end
        ADDR_RAW_HI: begin
          for (int k = 4; k < NUM_DIGITS; k++) begin
            raw_q[7*k +: 7] <= writedata[8*(k-4) +: 7];
          end
        end
        default: ;
      endcase
    end
  end

  // Blink timer: half-period counter, phase toggles on wrap; a BLINK write restarts visible
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (wr && address == ADDR_BLINK) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (blink_q == '0) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else if (cnt_q == blink_q - BLINK_W'(1)) begin
      cnt_q   <= '0;
      phase_q <= ~phase_q;
    end else begin
      cnt_q <= cnt_q + BLINK_W'(1);
    end
  end

`ifdef SEG7_BRIGHTNESS_EN
  logic [3:0] bright_q, pwm_q;

  // Duty register and free-running pwm counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bright_q <= 4'hF;
      pwm_q    <= 4'h0;
    end else begin
      pwm_q <= pwm_q + 4'h1;
      if (wr && address == ADDR_BRIGHT) bright_q <= writedata[3:0];
    end
  end

  assign dim_off = (pwm_q > bright_q);
`else
  assign dim_off = 1'b0;
`endif

  // Zero-latency read mux; unstored digit bits read 0
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_VALUE: readdata[4*NUM_DIGITS-1:0] = value_q;
      ADDR_CTRL: begin
        readdata[CTRL_DECODE_OFS +: NUM_DIGITS] = decode_q;
        readdata[CTRL_BLANK_OFS +: NUM_DIGITS]  = blank_q;
        readdata[CTRL_BLINK_OFS +: NUM_DIGITS]  = blink_en_q;
      end
      ADDR_BLINK: readdata[BLINK_W-1:0] = blink_q;
      ADDR_RAW_LO: begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
          if (k < 4) readdata[8*k +: 7] = raw_q[7*k +: 7];
        end
      end
      ADDR_RAW_HI: begin
        for (int k = 4; k < NUM_DIGITS; k++) begin
          readdata[8*(k-4) +: 7] = raw_q[7*k +: 7];
        end
      end
      ADDR_STATUS: readdata[1:0] = {blink_q != '0, phase_q};
`ifdef SEG7_BRIGHTNESS_EN
      ADDR_BRIGHT: readdata[3:0] = bright_q;
`endif
      default: ;
    endcase
  end

  // Per-digit source select and off priority: blank, blink-off phase, pwm dim
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
    logic [6:0] dec_seg, src_seg;
    logic       dark;

    pcihellocore_seg7_hexdec u_hexdec (
      .nibble (value_q[4*k +: 4]),
      .seg    (dec_seg)
    );

    assign src_seg = decode_q[k] ? (ACTIVE_LOW ? ~dec_seg : dec_seg) : raw_q[7*k +: 7];
    assign dark    = blank_q[k] | (blink_en_q[k] & ~phase_q) | dim_off;
    assign out_d[8*k +: 8] = {1'b0, dark ? SegOff : src_seg};
  end

  // Registered output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port <= {NUM_DIGITS{1'b0, RESET_SEG}};
    end else begin
      out_port <= out_d;
    end
  end

endmodule

// File: tb/tb_pcihellocore_seg7_ctrl.sv
// Self-checking bench for pcihellocore_seg7_ctrl, four digits, active-low segments.
module tb_pcihellocore_seg7_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [31:0] out_port;

  int errors = 0;
  int checks = 0;

  pcihellocore_seg7_ctrl #(
    .NUM_DIGITS (4),
    .ACTIVE_LOW (1'b1),
    .BLINK_W    (24),
    .RESET_SEG  (7'h40)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  // Standard active-low HEX glyphs 0..F
  localparam logic [6:0] HEX_AL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: register words as they read back, plus edges since the last BLINK write/reset
  logic [31:0] m_value, m_ctrl, m_blink, m_raw_lo, exp_out;
  int          m_since;

  function automatic bit m_phase();
    if (m_blink == 0) return 1'b1;
    return ((m_since / int'(m_blink)) % 2) == 0;
  endfunction

  function automatic logic [31:0] model_out();
    logic [31:0] o;
    logic [6:0]  s;
    o = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_ctrl[8+k])                      s = 7'h7F;
      else if (m_ctrl[16+k] && !m_phase())  s = 7'h7F;
      else if (m_ctrl[k])                   s = HEX_AL[m_value[4*k +: 4]];
      else                                  s = m_raw_lo[8*k +: 7];
      o[8*k +: 8] = {1'b0, s};
    end
    return o;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_value;
      3'd1:    return m_ctrl;
      3'd2:    return m_blink;
      3'd3:    return m_raw_lo;
      3'd5:    return {30'd0, m_blink != 0, m_phase()};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_value  <= 32'h0;
      m_ctrl   <= 32'h0;
      m_blink  <= 32'h0;
      m_raw_lo <= 32'h40404040;
      m_since  <= 0;
      exp_out  <= 32'h40404040;
    end else begin
      exp_out <= model_out();
      m_since <= m_since + 1;
      if (chipselect && !write_n) begin
        case (address)
          3'd0: m_value  <= writedata & 32'h0000FFFF;
          3'd1: m_ctrl   <= writedata & 32'h000F0F0F;
          3'd2: begin
            m_blink <= writedata & 32'h00FFFFFF;
            m_since <= 0;
          end
          3'd3: m_raw_lo <= writedata & 32'h7F7F7F7F;
          default: ;
        endcase
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every-cycle output compare against the model
  always @(negedge clk) begin
    check("out_port_model", out_port, exp_out);
  end

  // Tasks are entered just after a negedge
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input string name, input logic [2:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(name, readdata, model_read(a));
    chipselect = 1'b0;
  endtask

  task automatic rd_lit(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    check(name, readdata, exp);
    chipselect = 1'b0;
  endtask

  initial begin
    int  vis;
    bit  found;
    reset_n = 1'b0; address = 3'd0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: reset state
    check("reset_out", out_port, 32'h40404040);
    rd_lit("reset_raw_lo", 3'd3, 32'h40404040);
    rd_lit("reset_status", 3'd5, 32'h1);
    rd("reset_value", 3'd0);

    // 2: hex decode, two-edge latency
    @(negedge clk);
    wr(3'd0, 32'h0000_3210);
    wr(3'd1, 32'h0000_000F);
    @(negedge clk);
    check("decode_out", out_port, 32'h30247940);
    rd_lit("value_read", 3'd0, 32'h3210);
    wr(3'd0, 32'hFFFF_CA95);
    @(negedge clk);
    check("decode_out2", out_port, 32'h46081012);
    rd("ctrl_read", 3'd1);
    wr(3'd0, 32'h0000_3210);

    // 3: blink digit0 with half-period 4
    wr(3'd2, 32'd4);
    wr(3'd1, 32'h0001_000F);
    repeat (2) @(negedge clk);
    vis = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_port[7:0] == 8'h40) vis++;
      @(negedge clk);
    end
    check("blink_duty", 32'(vis), 32'd8);
    rd("blink_read", 3'd2);
    rd("status_blink", 3'd5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (out_port[7:0] == 8'h7F) found = 1'b1;
      else @(negedge clk);
    end
    check("blink_off_seen", 32'(found), 32'd1);
    wr(3'd2, 32'd4);
    @(posedge clk); #1;
    check("blink_rewrite_visible", {24'd0, out_port[7:0]}, 32'h40);
    @(negedge clk);

    // 4: blank overrides blink; unmapped write ignored
    wr(3'd1, 32'h0001_010F);
    wr(3'd2, 32'd2);
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      check("blank_wins", out_port, 32'h3024797F);
      @(negedge clk);
    end
    wr(3'd7, 32'hFFFF_FFFF);
    wr(3'd5, 32'hFFFF_FFFF);
    repeat (2) @(negedge clk);
    check("addr7_no_change", out_port, 32'h3024797F);
    rd_lit("addr7_read", 3'd7, 32'h0);
    rd_lit("addr6_read", 3'd6, 32'h0);

    // raw segments on digit0, bit7 of raw bytes not stored
    wr(3'd1, 32'h0000_000E);
    wr(3'd3, 32'hFF80_7F01);
    @(negedge clk);
    check("raw_out", out_port, 32'h30247901);
    rd_lit("raw_lo_read", 3'd3, 32'h7F007F01);
    rd_lit("raw_hi_read", 3'd4, 32'h0);

    // 5: async reset mid-blink and mid-write
    wr(3'd1, 32'h0001_000F);
    wr(3'd2, 32'd3);
    repeat (5) @(negedge clk);
    address = 3'd0; writedata = 32'hFFFF_FFFF; chipselect = 1'b1; write_n = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset_out", out_port, 32'h40404040);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    reset_n = 1'b1;
    rd_lit("post_reset_status", 3'd5, 32'h1);
    rd_lit("post_reset_value", 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    check("post_reset_out", out_port, 32'h40404040);

    // 6: brightness register absent in the default build
    wr(3'd6, 32'h3);
    rd_lit("bright_absent", 3'd6, 32'h0);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
